// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO: round-robin burst grants between two
// consumers, with one registered output stage and valid/ready flow control.
module fifo_rd_arbiter #(
   parameter int DSIZE = 8,
   parameter int BURST = 4,
   parameter int CNT_W = $clog2(BURST + 1)
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic [1:0]       req,
   input  logic [1:0]       out_ready,
   output logic [1:0]       gnt,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic             out_id,
   output logic             burst_done
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             id_q, id_d;
   logic             rr_last_q, rr_last_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] delivered_q, delivered_d;
   logic             out_valid_q, out_valid_d;
   logic [DSIZE-1:0] out_data_q, out_data_d;
   logic             out_id_q, out_id_d;

   logic pop, accept, last_acc, release_g, done, pick;

   always_comb begin
      accept   = out_valid_q && out_ready[out_id_q];
      // rinc depends only on flops and control inputs, never on rdata
      pop      = (state_q == GRANT) && !rrst && !rempty && req[id_q]
                 && (issued_q < BURST_C)
                 && (!out_valid_q || out_ready[id_q]);
      last_acc = accept && (delivered_q == BURST_C - ONE_C);
      release_g = !req[id_q] && (!out_valid_q || accept) && !pop;
      done     = (state_q == GRANT) && !rrst && (last_acc || release_g);

      pick        = 1'b0;
      state_d     = state_q;
      gnt_d       = gnt_q;
      id_d        = id_q;
      rr_last_d   = rr_last_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;

      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               unique case (1'b1)
                  (req == 2'b11): pick = ~rr_last_q;
                  (req != 2'b11): pick = req[1];
               endcase
               gnt_d       = pick ? 2'b10 : 2'b01;
               id_d        = pick;
               issued_d    = '0;
               delivered_d = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (pop) begin
               out_data_d  = rdata;
               out_valid_d = 1'b1;
               out_id_d    = id_q;
               issued_d    = issued_q + ONE_C;
            end else if (accept) begin
               out_valid_d = 1'b0;
            end
            if (accept) delivered_d = delivered_q + ONE_C;
            if (done) begin
               gnt_d     = 2'b00;
               rr_last_d = id_q;
               state_d   = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q     <= IDLE;
         gnt_q       <= 2'b00;
         id_q        <= 1'b0;
         rr_last_q   <= 1'b1;
         issued_q    <= '0;
         delivered_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         id_q        <= id_d;
         rr_last_q   <= rr_last_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign rinc       = pop;
   assign burst_done = done;
   assign gnt        = gnt_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_id     = out_id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO model, cycle tables for reset/single burst,
// scoreboard of {id,data} for the multi-cycle sequences.
module tb_fifo_rd_arbiter;

   logic       clk = 1'b0;
   logic       rrst;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic [1:0] req;
   logic [1:0] out_ready;
   logic [1:0] gnt;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_id;
   logic       burst_done;

   always #5 clk = ~clk;

   fifo_rd_arbiter #(.DSIZE(8), .BURST(4)) dut (
      .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
      .rinc(rinc), .req(req), .out_ready(out_ready), .gnt(gnt),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .burst_done(burst_done)
   );

   logic [7:0] mem [64];
   int rd_ptr = 0;
   int wr_ptr = 0;
   assign rempty = (rd_ptr == wr_ptr);
   assign rdata  = mem[rd_ptr[5:0]];

   typedef struct {
      logic       rrst;
      logic [1:0] req;
      logic [1:0] rdy;
      logic [1:0] gnt;
      logic       rinc;
      logic       ov;
      logic       bd;
   } vec_t;

   typedef struct {
      logic       id;
      logic [7:0] data;
   } exp_t;

   vec_t tv[$];
   exp_t sb[$];
   logic gnt_log[$];

   int n_cmp = 0;
   int n_err = 0;
   int rinc_cnt = 0;
   int bd_cnt = 0;
   logic do_pop = 1'b0;
   logic stall_prev = 1'b0;
   logic [7:0] prev_data = '0;
   logic [1:0] prev_gnt = 2'b00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] q,
                               input logic [1:0] y, input logic [1:0] g,
                               input logic ri, input logic ov,
                               input logic bd);
      vec_t v;
      v.rrst = r; v.req = q; v.rdy = y;
      v.gnt = g; v.rinc = ri; v.ov = ov; v.bd = bd;
      return v;
   endfunction

   task automatic wr_fifo(input logic [7:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr++;
   endtask

   task automatic expect_word(input logic id, input logic [7:0] d);
      exp_t e;
      e.id = id; e.data = d;
      sb.push_back(e);
   endtask

   task automatic half_a();
      logic stall;
      exp_t e;
      @(negedge clk);
      do_pop = (rinc === 1'b1);
      if (do_pop) rinc_cnt++;
      if (burst_done === 1'b1) bd_cnt++;
      chk("rinc_while_empty", {31'd0, (rinc === 1'b1) && rempty}, 0);
      if (gnt !== 2'b00 && prev_gnt === 2'b00) gnt_log.push_back(gnt[1]);
      prev_gnt = gnt;
      if (stall_prev) begin
         chk("hold_valid", {31'd0, out_valid}, 1);
         chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      stall = !rrst && (out_valid === 1'b1) && !out_ready[out_id];
      if (stall) chk("pop_over_pending", {31'd0, rinc}, 0);
      stall_prev = stall;
      prev_data = out_data;
      if (!rrst && out_valid === 1'b1 && out_ready[out_id] === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_extra_word", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("sb_data", {24'd0, out_data}, {24'd0, e.data});
            chk("sb_id", {31'd0, out_id}, {31'd0, e.id});
         end
      end
   endtask

   task automatic half_b();
      @(posedge clk);
      #1;
      if (do_pop) rd_ptr++;
   endtask

   task automatic tick();
      half_a();
      half_b();
   endtask

   task automatic run_tbl();
      foreach (tv[i]) begin
         rrst = tv[i].rrst; req = tv[i].req; out_ready = tv[i].rdy;
         half_a();
         chk($sformatf("tbl%0d_gnt", i), {30'd0, gnt}, {30'd0, tv[i].gnt});
         chk($sformatf("tbl%0d_rinc", i), {31'd0, rinc}, {31'd0, tv[i].rinc});
         chk($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tv[i].ov});
         chk($sformatf("tbl%0d_bd", i), {31'd0, burst_done}, {31'd0, tv[i].bd});
         half_b();
      end
      tv.delete();
   endtask

   task automatic rst_tick();
      rrst = 1'b1; req = 2'b00; out_ready = 2'b11;
      tick();
      rrst = 1'b0;
   endtask

   initial begin
      int bd0, rc0, base, k;
      rrst = 1'b1; req = 2'b11; out_ready = 2'b00;
      @(posedge clk); #1;

      // reset hold, first grant to 0, then reset drops the registered word
      wr_fifo(8'h5A);
      for (int i = 0; i < 3; i++) tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 0));
      tv.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
      tv.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 0, 0));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b01, 0, 1, 0));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 0));
      run_tbl();

      // single burst of four from A0..A5
      wr_ptr = rd_ptr;
      for (int i = 0; i < 6; i++) wr_fifo(8'hA0 + 8'(i));
      for (int i = 0; i < 4; i++) expect_word(1'b0, 8'hA0 + 8'(i));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b00, 0, 0, 0));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b01, 1, 0, 0));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b01, 1, 1, 0));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b01, 1, 1, 0));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b01, 1, 1, 0));
      tv.push_back(mk(0, 2'b01, 2'b11, 2'b01, 0, 1, 1));
      tv.push_back(mk(0, 2'b00, 2'b11, 2'b00, 0, 0, 0));
      run_tbl();
      chk("t2_fifo_left", wr_ptr - rd_ptr, 2);
      chk("t2_sb_empty", sb.size(), 0);
      wr_ptr = rd_ptr;

      // round-robin with both requesting
      rst_tick();
      for (int i = 0; i < 12; i++) begin
         wr_fifo(8'hB0 + 8'(i));
         expect_word((i / 4) == 1, 8'hB0 + 8'(i));
      end
      base = gnt_log.size();
      req = 2'b11; out_ready = 2'b11;
      k = 0;
      while (sb.size() > 0 && k < 100) begin tick(); k++; end
      chk("t3_timeout", sb.size(), 0);
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick();
      chk("t3_ngrants", {31'd0, gnt_log.size() >= base + 3}, 1);
      if (gnt_log.size() >= base + 3) begin
         chk("t3_g0", {31'd0, gnt_log[base]}, 0);
         chk("t3_g1", {31'd0, gnt_log[base+1]}, 1);
         chk("t3_g2", {31'd0, gnt_log[base+2]}, 0);
      end

      // empty stall inside a grant
      rst_tick();
      wr_fifo(8'hC0); wr_fifo(8'hC1);
      for (int i = 0; i < 4; i++) expect_word(1'b0, 8'hC0 + 8'(i));
      bd0 = bd_cnt;
      req = 2'b01; out_ready = 2'b11;
      for (int i = 0; i < 10; i++) tick();
      chk("t4_gnt_held", {30'd0, gnt}, 32'd1);
      chk("t4_two_done", sb.size(), 2);
      chk("t4_no_end", bd_cnt - bd0, 0);
      wr_fifo(8'hC2);
      k = 0;
      while (sb.size() > 1 && k < 20) begin tick(); k++; end
      chk("t4_third", sb.size(), 1);
      wr_fifo(8'hC3);
      k = 0;
      while (bd_cnt == bd0 && k < 20) begin tick(); k++; end
      chk("t4_sb_empty", sb.size(), 0);
      chk("t4_one_end", bd_cnt - bd0, 1);
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick();

      // backpressure on consumer 0, consumer 1 ready ignored
      rst_tick();
      for (int i = 0; i < 8; i++) begin
         wr_fifo(8'hD0 + 8'(i));
         expect_word(1'b0, 8'hD0 + 8'(i));
      end
      req = 2'b01;
      k = 0;
      while (sb.size() > 0 && k < 150) begin
         out_ready = {1'b1, (k % 4 == 0) || (k % 4 == 3)};
         tick();
         k++;
      end
      chk("t5_all_words", sb.size(), 0);
      req = 2'b00; out_ready = 2'b11;
      for (int i = 0; i < 3; i++) tick();

      // early release after two pops, then consumer 1
      rst_tick();
      for (int i = 0; i < 4; i++) wr_fifo(8'hE0 + 8'(i));
      expect_word(1'b0, 8'hE0); expect_word(1'b0, 8'hE1);
      expect_word(1'b1, 8'hE2); expect_word(1'b1, 8'hE3);
      rc0 = rinc_cnt; bd0 = bd_cnt;
      req = 2'b01; out_ready = 2'b11;
      k = 0;
      while (rinc_cnt - rc0 < 2 && k < 10) begin tick(); k++; end
      req = 2'b10;
      k = 0;
      while (sb.size() > 0 && k < 30) begin tick(); k++; end
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_one_end", bd_cnt - bd0, 1);
      chk("t6_gnt1", {30'd0, gnt}, 32'd2);
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick();
      chk("t6_second_end", bd_cnt - bd0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
